// File: rtl/au_gray_cnt_if.sv
// Control and result bundle for au_gray_cnt: count/load controls in, binary/Gray count and terminal count out.
interface au_gray_cnt_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic             up;
   logic             ld;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] g;
   logic             tc;

   modport master (
      output en, up, ld, ld_val,
      input  b, g, tc
   );

   modport slave (
      input  en, up, ld, ld_val,
      output b, g, tc
   );
endinterface

// File: rtl/au_gray_cnt.sv
// Up/down binary counter with registered binary and Gray outputs, load, wrap/saturate and terminal count.
// Optional macro AU_GRAY_CNT_LDG_EN: ld_val is Gray-coded and decoded to binary before loading.
module au_gray_cnt #(
   parameter int WIDTH    = 8,
   parameter int INIT     = 0,
   parameter int SATURATE = 0
) (
   input  logic          clk,
   input  logic          rst,
   au_gray_cnt_if.slave  bus
);

   localparam logic [WIDTH-1:0] INIT_B = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] MAX_B  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO_B = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE_B  = WIDTH'(1);

   if (WIDTH < 1) begin : g_bad_width
      $fatal(1, "au_gray_cnt: WIDTH must be >= 1");
   end
   if ((INIT < 0) || ((WIDTH < 31) && (INIT >= (1 << WIDTH)))) begin : g_bad_init
      $fatal(1, "au_gray_cnt: INIT out of range for WIDTH");
   end
   if ((SATURATE != 0) && (SATURATE != 1)) begin : g_bad_sat
      $fatal(1, "au_gray_cnt: SATURATE must be 0 or 1");
   end

   function automatic logic [WIDTH-1:0] gray_f(input logic [WIDTH-1:0] x);
      return x ^ (x >> 1);
   endfunction

   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] g_q, g_d;
   logic [WIDTH-1:0] ld_bin_s;

`ifdef AU_GRAY_CNT_LDG_EN
   // Prefix XOR from the MSB down turns a Gray word back into binary.
   function automatic logic [WIDTH-1:0] gray2bin_f(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      r = x;
      for (int i = WIDTH - 2; i >= 0; i--) begin
         r[i] = r[i+1] ^ x[i];
      end
      return r;
   endfunction

   assign ld_bin_s = gray2bin_f(bus.ld_val);
`else
   assign ld_bin_s = bus.ld_val;
`endif

   // Next-state selection: load beats count; saturate mode pins the count at either end.
   always_comb begin
      b_d = b_q;
      g_d = g_q;
      if (bus.ld) begin
         b_d = ld_bin_s;
         g_d = gray_f(ld_bin_s);
      end else if (bus.en) begin
         if (bus.up) begin
            if ((SATURATE == 1) && (b_q == MAX_B)) begin
               b_d = b_q;
            end else begin
               b_d = b_q + ONE_B;
            end
         end else begin
            if ((SATURATE == 1) && (b_q == ZERO_B)) begin
               b_d = b_q;
            end else begin
               b_d = b_q - ONE_B;
            end
         end
         g_d = gray_f(b_d);
      end else begin
         b_d = b_q;
         g_d = g_q;
      end
   end

   // State registers; g is registered alongside b so both are clean flop outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         b_q <= INIT_B;
         g_q <= gray_f(INIT_B);
      end else begin
         b_q <= b_d;
         g_q <= g_d;
      end
   end

   assign bus.b  = b_q;
   assign bus.g  = g_q;
   assign bus.tc = (bus.up & (b_q == MAX_B)) | (~bus.up & (b_q == ZERO_B));

endmodule
